i2c_temp_responder: RTL

Synthesizable I2C slave emulating a TMP101 temperature sensor, the responder end of the two-wire read transaction issued by our I2C read master. It answers slave address {4'b1001, AddressPins}, returns a 2-byte temperature (integer Celsius byte, then fraction byte) on reads, and accepts and acknowledges written bytes. It lets the read master and display path be exercised on-board and in simulation without a physical sensor.

---
 rtl/i2c_temp_responder.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/i2c_temp_responder.sv
// I2C slave that answers like a TMP101: returns a snapshotted integer/fraction
// temperature pair on reads and acknowledges and reports bytes on writes.
module i2c_temp_responder #(
  parameter logic [3:0] SlaveBase = 4'b1001
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [2:0] AddressPins,
  input  logic [7:0] TempInteger,
  input  logic [7:0] TempFraction,
  input  logic       SCL,
  inout  wire        SDA,
  output logic [7:0] WriteData,
  output logic       WriteValid,
  output logic       ReadDone,
  output logic       Busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_TX, S_TX_ACK, S_RX, S_RX_ACK, S_IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic        scl_s1_q, scl_s2_q, scl_prev_q;
  logic        sda_s1_q, sda_s2_q, sda_prev_q;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] tx_buf_q, tx_buf_d;
  logic        byte_idx_q, byte_idx_d;
  logic        rw_q, rw_d;
  logic        drive_req_q, drive_req_d;
  logic        sda_drive_q;
  logic [7:0]  write_data_q, write_data_d;
  logic        write_valid_q, write_valid_d;
  logic        read_done_q, read_done_d;
  logic        busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in, tx_byte;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  // Bus conditions only count while SCL has been high for two samples.
  assign start_det = scl_s2_q & scl_prev_q & ~sda_s2_q & sda_prev_q;
  assign stop_det  = scl_s2_q & scl_prev_q & sda_s2_q & ~sda_prev_q;
  assign shift_in  = {shift_q[6:0], sda_s2_q};
  assign tx_byte   = byte_idx_q ? tx_buf_q[7:0] : tx_buf_q[15:8];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    shift_d       = shift_q;
    tx_buf_d      = tx_buf_q;
    byte_idx_d    = byte_idx_q;
    rw_d          = rw_q;
    drive_req_d   = drive_req_q;
    write_data_d  = write_data_q;
    write_valid_d = 1'b0;
    read_done_d   = 1'b0;
    if (start_det) begin
      state_d     = S_ADDR;
      cnt_d       = 4'd0;
      drive_req_d = 1'b0;
    end else if (stop_det) begin
      state_d     = S_IDLE;
      drive_req_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d = 4'd0;
            if (shift_in[7:1] == {SlaveBase, AddressPins}) begin
              rw_d       = shift_in[0];
              tx_buf_d   = {TempInteger, TempFraction};
              byte_idx_d = 1'b0;
              state_d    = S_ADDR_ACK;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        // cnt 0: fall that opens the ACK slot; cnt 1: fall that closes it.
        S_ADDR_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            drive_req_d = 1'b1;
            cnt_d       = 4'd1;
          end else if (rw_q) begin
            state_d     = S_TX;
            drive_req_d = ~tx_byte[7];
            cnt_d       = 4'd1;
          end else begin
            state_d     = S_RX;
            drive_req_d = 1'b0;
            cnt_d       = 4'd0;
          end
        end
        S_TX: if (scl_fall) begin
          if (cnt_q == 4'd8) begin
            drive_req_d = 1'b0;
            cnt_d       = 4'd0;
            state_d     = S_TX_ACK;
          end else begin
            drive_req_d = ~tx_byte[~cnt_q[2:0]];
            cnt_d       = cnt_q + 4'd1;
          end
        end
        S_TX_ACK: if (scl_rise) begin
          if (!sda_s2_q) begin
            byte_idx_d = ~byte_idx_q;
            state_d    = S_TX;
          end else begin
            read_done_d = 1'b1;
            state_d     = S_IGNORE;
          end
        end
        S_RX: if (scl_rise) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            cnt_d   = 4'd0;
            state_d = S_RX_ACK;
          end
        end
        S_RX_ACK: if (scl_fall) begin
          if (cnt_q == 4'd0) begin
            drive_req_d   = 1'b1;
            write_data_d  = shift_q;
            write_valid_d = 1'b1;
            cnt_d         = 4'd1;
          end else begin
            drive_req_d = 1'b0;
            cnt_d       = 4'd0;
            state_d     = S_RX;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == S_ADDR_ACK) || (state_d == S_TX) || (state_d == S_TX_ACK) ||
             (state_d == S_RX) || (state_d == S_RX_ACK);
  end

  always_ff @(posedge clock or posedge Reset) begin
    if (Reset) begin
      scl_s1_q      <= 1'b1;
      scl_s2_q      <= 1'b1;
      scl_prev_q    <= 1'b1;
      sda_s1_q      <= 1'b1;
      sda_s2_q      <= 1'b1;
      sda_prev_q    <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      shift_q       <= 8'h00;
      tx_buf_q      <= 16'h0000;
      byte_idx_q    <= 1'b0;
      rw_q          <= 1'b0;
      drive_req_q   <= 1'b0;
      sda_drive_q   <= 1'b0;
      write_data_q  <= 8'h00;
      write_valid_q <= 1'b0;
      read_done_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      scl_s1_q      <= SCL;
      scl_s2_q      <= scl_s1_q;
      scl_prev_q    <= scl_s2_q;
      sda_s1_q      <= SDA;
      sda_s2_q      <= sda_s1_q;
      sda_prev_q    <= sda_s2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      tx_buf_q      <= tx_buf_d;
      byte_idx_q    <= byte_idx_d;
      rw_q          <= rw_d;
      drive_req_q   <= drive_req_d;
      sda_drive_q   <= drive_req_q;
      write_data_q  <= write_data_d;
      write_valid_q <= write_valid_d;
      read_done_q   <= read_done_d;
      busy_q        <= busy_d;
    end
  end

  assign SDA        = sda_drive_q ? 1'b0 : 1'bz;
  assign WriteData  = write_data_q;
  assign WriteValid = write_valid_q;
  assign ReadDone   = read_done_q;
  assign Busy       = busy_q;

endmodule
